// File: rtl/i2c_master_byte_ctrl.sv
// I2C byte-level controller: turns host byte commands into
// bit commands for the bit controller, shifting data MSB first.
module i2c_master_byte_ctrl (
    input  logic       clk,
    input  logic       nReset,
    input  logic       rst,
    input  logic       ena,
    input  logic       start,
    input  logic       stop,
    input  logic       read,
    input  logic       write,
    input  logic       ack_in,
    input  logic [7:0] din,
    output logic       cmd_ack,
    output logic       ack_out,
    output logic [7:0] dout,
    output logic       i2c_busy,
    output logic       i2c_al,
    output logic [3:0] core_cmd,
    output logic       core_txd,
    input  logic       core_ack,
    input  logic       core_rxd,
    input  logic       core_al,
    input  logic       core_busy
);

    localparam logic [3:0] CMD_NOP   = 4'b0000;
    localparam logic [3:0] CMD_START = 4'b0001;
    localparam logic [3:0] CMD_STOP  = 4'b0010;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_READ  = 4'b1000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WRITE,
        ST_READ,
        ST_ACK,
        ST_STOP
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cmd_q, cmd_d;
    logic        cmd_ack_q, cmd_ack_d;
    logic        ack_out_q, ack_out_d;
    logic [7:0]  sr_q, sr_d;
    logic [2:0]  dcnt_q, dcnt_d;
    logic        rd_op_q, rd_op_d;
    logic        go;

    // cmd_ack masks the cycle where the host still holds its request
    assign go = (read | write | stop) & ~cmd_ack_q & ena;

    assign cmd_ack  = cmd_ack_q;
    assign ack_out  = ack_out_q;
    assign dout     = sr_q;
    assign core_cmd = cmd_q;
    assign i2c_busy = core_busy;
    assign i2c_al   = core_al;

    // Next-state and registered-output logic of the byte FSM
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        cmd_ack_d = 1'b0;
        ack_out_d = ack_out_q;
        sr_d      = sr_q;
        dcnt_d    = dcnt_q;
        rd_op_d   = rd_op_q;
        if (core_al) begin
            // lost arbitration: drop the transfer, keep data intact
            state_d = ST_IDLE;
            cmd_d   = CMD_NOP;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        sr_d    = din;
                        dcnt_d  = 3'd7;
                        rd_op_d = read;
                        if (start) begin
                            state_d = ST_START;
                            cmd_d   = CMD_START;
                        end else if (read) begin
                            state_d = ST_READ;
                            cmd_d   = CMD_READ;
                        end else if (write) begin
                            state_d = ST_WRITE;
                            cmd_d   = CMD_WRITE;
                        end else begin
                            state_d = ST_STOP;
                            cmd_d   = CMD_STOP;
                        end
                    end
                end
                ST_START: begin
                    if (core_ack) begin
                        sr_d   = din;
                        dcnt_d = 3'd7;
                        if (read) begin
                            state_d = ST_READ;
                            cmd_d   = CMD_READ;
                        end else begin
                            state_d = ST_WRITE;
                            cmd_d   = CMD_WRITE;
                        end
                    end
                end
                ST_WRITE, ST_READ: begin
                    if (core_ack) begin
                        sr_d = {sr_q[6:0], core_rxd};
                        if (dcnt_q == 3'd0) begin
                            state_d = ST_ACK;
                            // ACK bit direction is opposite to data
                            cmd_d = (state_q == ST_READ) ? CMD_WRITE
                                                         : CMD_READ;
                        end else begin
                            dcnt_d = dcnt_q - 3'd1;
                        end
                    end
                end
                ST_ACK: begin
                    if (core_ack) begin
                        ack_out_d = core_rxd;
                        if (stop) begin
                            state_d = ST_STOP;
                            cmd_d   = CMD_STOP;
                        end else begin
                            state_d   = ST_IDLE;
                            cmd_d     = CMD_NOP;
                            cmd_ack_d = 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (core_ack) begin
                        state_d   = ST_IDLE;
                        cmd_d     = CMD_NOP;
                        cmd_ack_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cmd_d   = CMD_NOP;
                end
            endcase
        end
    end

    // Bit to put on the bus: data in WRITE, host ACK after a read
    always_comb begin
        core_txd = 1'b1;
        if (state_q == ST_WRITE) begin
            core_txd = sr_q[7];
        end else if (state_q == ST_ACK && rd_op_q) begin
            core_txd = ack_in;
        end
    end

    // State registers with synchronous hard and soft reset
    always_ff @(posedge clk) begin
        if (!nReset || rst) begin
            state_q   <= ST_IDLE;
            cmd_q     <= CMD_NOP;
            cmd_ack_q <= 1'b0;
            ack_out_q <= 1'b0;
            sr_q      <= 8'h00;
            dcnt_q    <= 3'd0;
            rd_op_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            cmd_ack_q <= cmd_ack_d;
            ack_out_q <= ack_out_d;
            sr_q      <= sr_d;
            dcnt_q    <= dcnt_d;
            rd_op_q   <= rd_op_d;
        end
    end

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Directed bench for i2c_master_byte_ctrl with a hand-driven
// bit-controller model acknowledging each bit command.
module tb_i2c_master_byte_ctrl;

    localparam int C_NOP   = 0;
    localparam int C_START = 1;
    localparam int C_STOP  = 2;
    localparam int C_WRITE = 4;
    localparam int C_READ  = 8;

    logic       clk = 1'b0;
    logic       nReset, rst, ena;
    logic       start, stop, read, write, ack_in;
    logic [7:0] din;
    logic       cmd_ack, ack_out, i2c_busy, i2c_al;
    logic [7:0] dout;
    logic [3:0] core_cmd;
    logic       core_txd;
    logic       core_ack, core_rxd, core_al, core_busy;

    int n_vec = 0;
    int n_err = 0;
    int n_ack = 0;
    int n0;
    logic [7:0] v;

    i2c_master_byte_ctrl dut (
        .clk       (clk),
        .nReset    (nReset),
        .rst       (rst),
        .ena       (ena),
        .start     (start),
        .stop      (stop),
        .read      (read),
        .write     (write),
        .ack_in    (ack_in),
        .din       (din),
        .cmd_ack   (cmd_ack),
        .ack_out   (ack_out),
        .dout      (dout),
        .i2c_busy  (i2c_busy),
        .i2c_al    (i2c_al),
        .core_cmd  (core_cmd),
        .core_txd  (core_txd),
        .core_ack  (core_ack),
        .core_rxd  (core_rxd),
        .core_al   (core_al),
        .core_busy (core_busy)
    );

    always #5 clk = ~clk;

    // Count cycles with cmd_ack high, sampled before the edge updates it
    always @(posedge clk) begin
        if (cmd_ack === 1'b1) n_ack <= n_ack + 1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Check the pending bit command, then acknowledge it for one cycle
    task automatic bit_step(input string tag, input int ecmd,
                            input int etxd, input logic rxd);
        chk({tag, "_cmd"}, int'(core_cmd), ecmd);
        chk({tag, "_txd"}, int'(core_txd), etxd);
        core_rxd = rxd;
        core_ack = 1'b1;
        @(negedge clk);
        core_ack = 1'b0;
    endtask

    initial begin
        nReset = 1'b0; rst = 1'b0; ena = 1'b1;
        start = 1'b0; stop = 1'b0; read = 1'b0; write = 1'b0;
        ack_in = 1'b0; din = 8'h00;
        core_ack = 1'b0; core_rxd = 1'b0; core_al = 1'b0;
        core_busy = 1'b1;
        repeat (3) @(negedge clk);
        nReset = 1'b1;

        // reset state
        chk("rst_cmd", int'(core_cmd), C_NOP);
        chk("rst_cmd_ack", int'(cmd_ack), 0);
        chk("rst_ack_out", int'(ack_out), 0);
        chk("rst_dout", int'(dout), 8'h00);
        chk("rst_txd", int'(core_txd), 1);
        chk("busy_pass", int'(i2c_busy), 1);
        core_busy = 1'b0;
        @(negedge clk);
        chk("busy_pass0", int'(i2c_busy), 0);

        // core_ack in IDLE is ignored
        bit_step("idle_ack", C_NOP, 1, 1'b1);
        chk("idle_ack_cmdack", int'(cmd_ack), 0);

        // ena low keeps the FSM idle
        ena = 1'b0; write = 1'b1;
        repeat (2) @(negedge clk);
        chk("ena_lo_cmd", int'(core_cmd), C_NOP);
        write = 1'b0; ena = 1'b1;
        @(negedge clk);

        // start + write A5
        n0 = n_ack;
        v = 8'hA5; din = v; start = 1'b1; write = 1'b1;
        @(negedge clk);
        bit_step("w_st", C_START, 1, 1'b0);
        for (int i = 0; i < 8; i++)
            bit_step($sformatf("w_b%0d", i), C_WRITE, int'(v[7-i]), 1'b0);
        bit_step("w_ack", C_READ, 1, 1'b0);
        chk("w_cmd_ack", int'(cmd_ack), 1);
        chk("w_cmd_nop", int'(core_cmd), C_NOP);
        chk("w_ack_out", int'(ack_out), 0);
        start = 1'b0; write = 1'b0;
        @(negedge clk);
        chk("w_ack_cnt", n_ack - n0, 1);

        // read 3C with NACK, bus returns 1 in ACK phase
        n0 = n_ack;
        v = 8'h3C; din = 8'h00; read = 1'b1; ack_in = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++)
            bit_step($sformatf("r_b%0d", i), C_READ, 1, v[7-i]);
        bit_step("r_ack", C_WRITE, 1, 1'b1);
        chk("r_cmd_ack", int'(cmd_ack), 1);
        chk("r_dout", int'(dout), 8'h3C);
        chk("r_ack_out", int'(ack_out), 1);
        read = 1'b0;
        @(negedge clk);
        chk("r_ack_cnt", n_ack - n0, 1);

        // stop only; request held through the cmd_ack cycle
        n0 = n_ack;
        stop = 1'b1;
        @(negedge clk);
        bit_step("s_stop", C_STOP, 1, 1'b0);
        chk("s_cmd_ack", int'(cmd_ack), 1);
        chk("s_cmd_nop", int'(core_cmd), C_NOP);
        @(negedge clk);
        chk("s_masked_cmd", int'(core_cmd), C_NOP);
        chk("s_ack_lo", int'(cmd_ack), 0);
        stop = 1'b0;
        @(negedge clk);
        chk("s_ack_cnt", n_ack - n0, 1);

        // arbitration lost after 4th write ack of FF
        n0 = n_ack;
        din = 8'hFF; write = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            bit_step($sformatf("al_b%0d", i), C_WRITE, 1, 1'b0);
        core_al = 1'b1; write = 1'b0;
        @(negedge clk);
        chk("al_cmd", int'(core_cmd), C_NOP);
        chk("al_pass", int'(i2c_al), 1);
        chk("al_cmd_ack", int'(cmd_ack), 0);
        chk("al_dout", int'(dout), 8'hF0);
        chk("al_txd", int'(core_txd), 1);
        core_al = 1'b0;
        @(negedge clk);
        chk("al_idle_cmd", int'(core_cmd), C_NOP);
        chk("al_ack_cnt", n_ack - n0, 0);

        // soft reset mid-read (dcnt = 3), then write 81
        n0 = n_ack;
        din = 8'h00; read = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            bit_step($sformatf("rr_b%0d", i), C_READ, 1, 1'b1);
        rst = 1'b1; core_ack = 1'b1; read = 1'b0;
        @(negedge clk);
        rst = 1'b0; core_ack = 1'b0;
        chk("rr_cmd", int'(core_cmd), C_NOP);
        chk("rr_dout", int'(dout), 8'h00);
        chk("rr_ack_out", int'(ack_out), 0);
        chk("rr_cmd_ack", int'(cmd_ack), 0);
        v = 8'h81; din = v; write = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++)
            bit_step($sformatf("rw_b%0d", i), C_WRITE, int'(v[7-i]), 1'b0);
        bit_step("rw_ack", C_READ, 1, 1'b0);
        chk("rw_cmd_ack", int'(cmd_ack), 1);
        write = 1'b0;
        @(negedge clk);
        chk("rr_ack_cnt", n_ack - n0, 1);

        // start + read + stop, ACK transmitted
        n0 = n_ack;
        v = 8'h96; din = 8'h00; ack_in = 1'b0;
        start = 1'b1; read = 1'b1; stop = 1'b1;
        @(negedge clk);
        bit_step("c_st", C_START, 1, 1'b0);
        for (int i = 0; i < 8; i++)
            bit_step($sformatf("c_b%0d", i), C_READ, 1, v[7-i]);
        bit_step("c_ack", C_WRITE, 0, 1'b0);
        chk("c_no_ack_yet", int'(cmd_ack), 0);
        bit_step("c_stop", C_STOP, 1, 1'b0);
        chk("c_cmd_ack", int'(cmd_ack), 1);
        chk("c_cmd_nop", int'(core_cmd), C_NOP);
        chk("c_dout", int'(dout), 8'h96);
        start = 1'b0; read = 1'b0; stop = 1'b0;
        @(negedge clk);
        chk("c_ack_cnt", n_ack - n0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_master_byte_ctrl.md
I2C_MASTER_BYTE_CTRL -- requirements
Module: i2c_master_byte_ctrl

Interface
REQ-001 The block SHALL have no parameters; the command encoding is fixed: NOP 4'b0000, START 4'b0001, STOP 4'b0010, WRITE 4'b0100, READ 4'b1000.
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 nReset  input  1  reset, synchronous, active-low.
REQ-004 rst  input  1  soft reset, synchronous, active-high; same effect as nReset.
REQ-005 ena  input  1  core enable; held low SHALL keep the FSM in IDLE with core_cmd = NOP.
REQ-006 start, stop, read, write  input  1 each  host command request bits, level-held until cmd_ack.
REQ-007 ack_in  input  1  ACK bit to transmit after a READ (0 = ACK, 1 = NACK).
REQ-008 din  input  8  byte to transmit, MSB first.
REQ-009 cmd_ack  output  1  one-cycle pulse: host command complete.
REQ-010 ack_out  output  1  ACK bit sampled from the bus in the ACK phase.
REQ-011 dout  output  8  received byte, equal to the shift register.
REQ-012 i2c_busy, i2c_al  output  1 each  combinational pass-through of core_busy and core_al.
REQ-013 core_cmd  output  4  command to the bit controller.
REQ-014 core_txd  output  1  bit to the bit controller.
REQ-015 core_ack, core_rxd, core_al, core_busy  input  1 each  from the bit controller: bit-command done, sampled bit, arbitration lost, bus busy.

Function
REQ-016 States SHALL be IDLE, START, WRITE, READ, ACK and STOP; there is a shift register sr[7:0], a bit counter dcnt[2:0], and a flag rd_op.
REQ-017 go SHALL equal (read | write | stop) & ~cmd_ack & ena.
- start alone does not trigger go.
- cmd_ack masks the cycle in which the request bits are still high.
REQ-018 IDLE transitions when go is high:
- If start: go to START with core_cmd = START.
- Else if read: go to READ with core_cmd = READ.
- Else if write: go to WRITE with core_cmd = WRITE.
- Else: go to STOP with core_cmd = STOP.
- In every case: sr <= din, dcnt <= 7, rd_op <= read.
REQ-019 START on core_ack: go to READ (core_cmd READ) if read, else to WRITE (core_cmd WRITE); sr <= din, dcnt <= 7.
REQ-020 WRITE/READ on core_ack:
- Always: sr <= {sr[6:0], core_rxd}.
- If dcnt == 0: go to ACK; core_cmd = WRITE after READ, READ after WRITE.
- Else: dcnt <= dcnt - 1 and the same command is reissued.
REQ-021 core_txd SHALL be combinational:
- sr[7] in WRITE.
- ack_in in ACK when rd_op = 1.
- 1 in all other states.
REQ-022 ACK on core_ack: ack_out <= core_rxd.
- If stop: go to STOP with core_cmd = STOP.
- Else: go to IDLE with core_cmd = NOP and cmd_ack = 1 in the next cycle.
REQ-023 STOP on core_ack: go to IDLE with core_cmd = NOP and cmd_ack = 1.
REQ-024 cmd_ack SHALL be registered and high for exactly one cycle per completed command; it is never asserted in the same cycle as any other transition out of IDLE.
REQ-025 core_ack while in IDLE SHALL be ignored.
REQ-026 Arbitration loss: core_al high in any cycle SHALL, next edge, force IDLE and core_cmd = NOP, leave cmd_ack low, and keep sr and ack_out unchanged; the host observes i2c_al.
REQ-027 Simultaneous start, read and stop SHALL run START, then READ, then ACK, then STOP, with a single cmd_ack at the end.
REQ-028 dcnt SHALL never wrap: it is decremented only when nonzero.

Reset
REQ-029 On nReset = 0 or rst = 1, the block SHALL at the next edge set: state IDLE, core_cmd NOP, cmd_ack 0, ack_out 0, sr 8'h00 (dout 8'h00), dcnt 0, rd_op 0.
REQ-030 Reset SHALL take priority over core_al, core_ack and go, including mid-byte; no cmd_ack is issued for the aborted command.

Verification
REQ-031 start=1, write=1, din=8'hA5, model acks each bit command -> core_cmd is START, then WRITE x8 with core_txd = 1,0,1,0,0,1,0,1, then READ; core_rxd=0 -> ack_out=0; one cmd_ack pulse.
REQ-032 read=1, ack_in=1, model returns bits 8'h3C -> READ x8, then WRITE with core_txd=1; dout=8'h3C; cmd_ack once.
REQ-033 stop=1 only -> core_cmd STOP; one cycle after core_ack, cmd_ack=1 and core_cmd=NOP.
REQ-034 core_al asserted after the 4th WRITE ack of 8'hFF -> next cycle IDLE, core_cmd NOP, i2c_al=1, no cmd_ack.
REQ-035 rst pulsed mid-READ (dcnt=3) -> IDLE, dout=8'h00, no cmd_ack; a subsequent write of 8'h81 completes normally.
REQ-036 start+read+stop all high, ack_in=0 -> sequence START, READ x8, WRITE (core_txd=0), STOP; cmd_ack exactly once, after the STOP core_ack.
